// File: rtl/decode_stage.sv
// RV32I decode stage: regfile address drive, RAW/WAW scoreboard, registered valid/ready output slot.
// Optional macro WB_BYPASS_EN forwards writeback data into a waiting source operand.
module decode_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input  logic            clk,
  input  logic            rstf,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [31:0]     in_pc,
  output logic [4:0]      addrA,
  output logic [4:0]      addrB,
  input  logic [XLEN-1:0] regA,
  input  logic [XLEN-1:0] regB,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_pc,
  output logic [XLEN-1:0] out_rs1v,
  output logic [XLEN-1:0] out_rs2v,
  output logic [31:0]     out_imm,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic            out_funct7b5,
  output logic            out_illegal,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic            valid;
    logic [31:0]     pc;
    logic [XLEN-1:0] rs1v;
    logic [XLEN-1:0] rs2v;
    logic [31:0]     imm;
    logic [4:0]      rd;
    logic            rd_we;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic            illegal;
  } bundle_t;

  bundle_t         bun_q, bun_d;
  logic [NREG-1:0] sb_q, sb_d;

  logic [6:0]      opcode;
  logic [4:0]      rs1, rs2, rd;
  logic [31:0]     imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0]     imm;
  logic            uses_rs1, uses_rs2, wr_class, legal;
  logic            writes_rd;
  logic            byp1, byp2;
  logic [XLEN-1:0] op_a, op_b;
  logic            hazard;
  logic            accept;

  assign opcode = in_instr[6:0];
  assign rd     = in_instr[11:7];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];
  assign addrA  = rs1;
  assign addrB  = rs2;

  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u = {in_instr[31:12], 12'h000};
  assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

  // Opcode class: register usage, immediate format and legality
  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    wr_class = 1'b0;
    legal    = 1'b1;
    imm      = 32'h0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        wr_class = 1'b1;
        imm      = imm_u;
      end
      OPC_JAL: begin
        wr_class = 1'b1;
        imm      = imm_j;
      end
      OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
        uses_rs1 = 1'b1;
        wr_class = 1'b1;
        imm      = imm_i;
      end
      OPC_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        imm      = imm_b;
      end
      OPC_STORE: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        imm      = imm_s;
      end
      OPC_OP: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        wr_class = 1'b1;
      end
      OPC_FENCE, OPC_SYSTEM: ;
      default: legal = 1'b0;
    endcase
  end

  assign writes_rd = wr_class & (rd != 5'd0);

`ifdef WB_BYPASS_EN
  // A source retiring this very cycle is taken from the writeback bus instead of stalling
  assign byp1 = wb_valid & (wb_rd == rs1) & (rs1 != 5'd0);
  assign byp2 = wb_valid & (wb_rd == rs2) & (rs2 != 5'd0);
  assign op_a = byp1 ? wb_data : regA;
  assign op_b = byp2 ? wb_data : regB;
`else
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
  assign op_a = regA;
  assign op_b = regB;
`endif

  // WAW on rd is never waived
  assign hazard = (uses_rs1 & sb_q[rs1] & ~byp1)
                | (uses_rs2 & sb_q[rs2] & ~byp2)
                | (writes_rd & sb_q[rd]);

  assign in_ready = ~hazard & (~bun_q.valid | out_ready) & ~flush;
  assign accept   = in_valid & in_ready;

  // Next slot contents and scoreboard; a set on accept overrides a same-cycle clear
  always_comb begin
    bun_d = bun_q;
    sb_d  = sb_q;
    if (wb_valid && (wb_rd != 5'd0)) sb_d[wb_rd] = 1'b0;
    if (flush) begin
      bun_d.valid = 1'b0;
      if (bun_q.valid && bun_q.rd_we) sb_d[bun_q.rd] = 1'b0;
    end else if (accept) begin
      bun_d.valid    = 1'b1;
      bun_d.pc       = in_pc;
      bun_d.rs1v     = op_a;
      bun_d.rs2v     = op_b;
      bun_d.imm      = imm;
      bun_d.rd       = rd;
      bun_d.rd_we    = writes_rd;
      bun_d.opcode   = opcode;
      bun_d.funct3   = in_instr[14:12];
      bun_d.funct7b5 = in_instr[30];
      bun_d.illegal  = ~legal;
      if (writes_rd) sb_d[rd] = 1'b1;
    end else if (bun_q.valid && out_ready) begin
      bun_d.valid = 1'b0;
    end
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      bun_q <= '0;
      sb_q  <= '0;
    end else begin
      bun_q <= bun_d;
      sb_q  <= sb_d;
    end
  end

  assign out_valid    = bun_q.valid;
  assign out_pc       = bun_q.pc;
  assign out_rs1v     = bun_q.rs1v;
  assign out_rs2v     = bun_q.rs2v;
  assign out_imm      = bun_q.imm;
  assign out_rd       = bun_q.rd;
  assign out_rd_we    = bun_q.rd_we;
  assign out_opcode   = bun_q.opcode;
  assign out_funct3   = bun_q.funct3;
  assign out_funct7b5 = bun_q.funct7b5;
  assign out_illegal  = bun_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed test-plan cases, then randomized traffic vs. a reference model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rstf = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic [4:0]  addrA, addrB;
  logic [31:0] regA = '0, regB = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc, out_rs1v, out_rs2v, out_imm;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic        out_funct7b5, out_illegal;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        flush = 1'b0;

  decode_stage dut (
    .clk(clk), .rstf(rstf), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .addrA(addrA), .addrB(addrB),
    .regA(regA), .regB(regB), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1v(out_rs1v), .out_rs2v(out_rs2v), .out_imm(out_imm),
    .out_rd(out_rd), .out_rd_we(out_rd_we), .out_opcode(out_opcode),
    .out_funct3(out_funct3), .out_funct7b5(out_funct7b5), .out_illegal(out_illegal),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] ADDI1 = 32'h00500093;  // addi x1,x0,5
  localparam logic [31:0] ADD2  = 32'h00108133;  // add  x2,x1,x1
  localparam logic [31:0] LUI5  = 32'h123452B7;  // lui  x5,0x12345
  localparam logic [31:0] ADDI6 = 32'h00128313;  // addi x6,x5,1
  localparam logic [31:0] BEQ   = 32'hFE000EE3;  // beq  x0,x0,-4
  localparam logic [31:0] ILL   = 32'h0000007F;

  typedef struct {
    logic [31:0] pc, rs1v, rs2v, imm;
    logic [4:0]  rd;
    logic        rd_we;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7b5, illegal;
  } exp_t;

  int checks = 0;
  int errors = 0;

  exp_t       exp_q[$];
  logic [4:0] retire_q[$];
  logic       msb [32];
  logic       m_full = 1'b0;
  exp_t       held;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sext(input logic [31:0] v, input int n);
    if (v[n-1]) return v - (32'd1 << n);
    return v;
  endfunction

  // Spec register-usage table
  function automatic void classify(input logic [6:0] op, output logic u1, output logic u2,
                                   output logic wr, output logic legal);
    u1 = 1'b0; u2 = 1'b0; wr = 1'b0; legal = 1'b1;
    case (op)
      7'b0110111, 7'b0010111, 7'b1101111: wr = 1'b1;
      7'b1100111, 7'b0000011, 7'b0010011: begin u1 = 1'b1; wr = 1'b1; end
      7'b1100011, 7'b0100011: begin u1 = 1'b1; u2 = 1'b1; end
      7'b0110011: begin u1 = 1'b1; u2 = 1'b1; wr = 1'b1; end
      7'b0001111, 7'b1110011: ;
      default: legal = 1'b0;
    endcase
  endfunction

  function automatic logic waived(input logic [4:0] r);
`ifdef WB_BYPASS_EN
    return wb_valid && (wb_rd == r) && (r != 5'd0);
`else
    return (r == 5'd31) && 1'b0;
`endif
  endfunction

  function automatic logic model_hazard(input logic [31:0] ins);
    logic u1, u2, wr, lg;
    classify(ins[6:0], u1, u2, wr, lg);
    return (u1 && msb[ins[19:15]] && !waived(ins[19:15])) ||
           (u2 && msb[ins[24:20]] && !waived(ins[24:20])) ||
           (wr && ins[11:7] != 5'd0 && msb[ins[11:7]]);
  endfunction

  function automatic exp_t model_decode(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic [31:0] ra, input logic [31:0] rb);
    exp_t e;
    logic u1, u2, wr, lg;
    classify(ins[6:0], u1, u2, wr, lg);
    e.pc = pc;
    e.rs1v = waived(ins[19:15]) ? wb_data : ra;
    e.rs2v = waived(ins[24:20]) ? wb_data : rb;
    case (ins[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: e.imm = sext(32'(ins[31:20]), 12);
      7'b0100011: e.imm = sext(32'({ins[31:25], ins[11:7]}), 12);
      7'b1100011: e.imm = sext(32'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}), 13);
      7'b0110111, 7'b0010111: e.imm = {ins[31:12], 12'h000};
      7'b1101111: e.imm = sext(32'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}), 21);
      default: e.imm = 32'h0;
    endcase
    e.rd = ins[11:7];
    e.rd_we = wr && (ins[11:7] != 5'd0);
    e.op = ins[6:0];
    e.f3 = ins[14:12];
    e.f7b5 = ins[30];
    e.illegal = !lg;
    return e;
  endfunction

  // Reference model: predicts in_ready/out_valid, queues expected bundles, tracks busy registers
  always @(negedge clk) begin
    if (rstf) begin
      logic exp_rdy;
      exp_t e;
      check("out_valid", 32'(out_valid), 32'(m_full));
      check("addr", 32'({addrA, addrB}), 32'({in_instr[19:15], in_instr[24:20]}));
      exp_rdy = !model_hazard(in_instr) && (!m_full || out_ready) && !flush;
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      if (wb_valid && wb_rd != 5'd0) msb[wb_rd] = 1'b0;
      if (flush) begin
        if (m_full && held.rd_we) msb[held.rd] = 1'b0;
        m_full = 1'b0;
      end else begin
        if (m_full && out_ready) begin
          if (held.rd_we) retire_q.push_back(held.rd);
          m_full = 1'b0;
        end
        if (in_valid && exp_rdy) begin
          e = model_decode(in_instr, in_pc, regA, regB);
          exp_q.push_back(e);
          held = e;
          m_full = 1'b1;
          if (e.rd_we) msb[e.rd] = 1'b1;
        end
      end
    end
  end

  // Monitor: compares every presented bundle with the queue head, pops on handshake or flush
  always @(negedge clk) begin
    if (rstf && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_bundle", 32'(out_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q[0];
        check("out_pc", out_pc, e.pc);
        check("out_rs1v", out_rs1v, e.rs1v);
        check("out_rs2v", out_rs2v, e.rs2v);
        check("out_imm", out_imm, e.imm);
        check("out_ctl", 32'({out_rd, out_rd_we, out_opcode, out_funct3, out_funct7b5, out_illegal}),
              32'({e.rd, e.rd_we, e.op, e.f3, e.f7b5, e.illegal}));
        if (flush || out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] ins, input logic ordy, input logic wbv,
                       input logic [4:0] wbr, input logic [31:0] wbd, input logic fl);
    @(posedge clk);
    #1;
    in_valid = v; in_instr = ins; in_pc = $urandom; regA = $urandom; regB = $urandom;
    out_ready = ordy; wb_valid = wbv; wb_rd = wbr; wb_data = wbd; flush = fl;
    #2;
  endtask

  task automatic clear_model();
    exp_q.delete();
    retire_q.delete();
    for (int i = 0; i < 32; i++) msb[i] = 1'b0;
    m_full = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  op;
    case ($urandom_range(0, 11))
      0: op = 7'b0110111;  1: op = 7'b0010111;  2: op = 7'b1101111;  3: op = 7'b1100111;
      4: op = 7'b1100011;  5: op = 7'b0000011;  6: op = 7'b0100011;  7: op = 7'b0010011;
      8: op = 7'b0110011;  9: op = 7'b0001111; 10: op = 7'b1110011;
      default: op = 7'($urandom);
    endcase
    r = $urandom;
    r[6:0] = op;
    r[11:7] = 5'($urandom_range(0, 7));
    r[19:15] = 5'($urandom_range(0, 7));
    r[24:20] = 5'($urandom_range(0, 7));
    return r;
  endfunction

  initial begin
    clear_model();
    repeat (2) @(posedge clk);
    #1 rstf = 1'b1;
    #1;
    check("rst_ctl", 32'({out_valid, out_rd, out_rd_we, out_opcode, out_funct3, out_funct7b5, out_illegal}), 32'd0);
    check("rst_data", out_pc | out_rs1v | out_rs2v | out_imm, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // addi x1 then dependent add
    drive(1, ADDI1, 1, 0, 0, 0, 0);
    check("addi_accept", 32'(in_ready), 32'd1);
    drive(1, ADD2, 1, 0, 0, 0, 0);
    check("addi_out", 32'({out_valid, out_rd_we, out_rd}), 32'({1'b1, 1'b1, 5'd1}));
    check("addi_imm", out_imm, 32'd5);
    check("raw_stall", 32'(in_ready), 32'd0);
    drive(1, ADD2, 1, 0, 0, 0, 0);
    check("raw_hold", 32'(in_ready), 32'd0);
    drive(1, ADD2, 1, 1, 5'd1, 32'd7, 0);
`ifdef WB_BYPASS_EN
    check("byp_same_cycle", 32'(in_ready), 32'd1);
    drive(0, 0, 1, 0, 0, 0, 0);
    check("byp_rs1v", out_rs1v, 32'd7);
    check("byp_rs2v", out_rs2v, 32'd7);
`else
    check("wb_same_cycle", 32'(in_ready), 32'd0);
    drive(1, ADD2, 1, 0, 0, 0, 0);
    check("wb_next_cycle", 32'(in_ready), 32'd1);
    drive(0, 0, 1, 0, 0, 0, 0);
`endif

    // backpressure, then flush of held lui x5
    drive(1, LUI5, 0, 0, 0, 0, 0);
    check("lui_accept", 32'(in_ready), 32'd1);
    drive(1, BEQ, 0, 0, 0, 0, 0);
    check("bp_stall", 32'(in_ready), 32'd0);
    drive(1, BEQ, 0, 0, 0, 0, 0);
    check("bp_hold", 32'(in_ready), 32'd0);
    drive(1, BEQ, 0, 0, 0, 0, 1);
    check("flush_noaccept", 32'(in_ready), 32'd0);
    check("flush_held_rd", 32'(out_rd), 32'd5);
    drive(1, ADDI6, 1, 0, 0, 0, 0);
    check("flush_kill", 32'(out_valid), 32'd0);
    check("flush_sb_clear", 32'(in_ready), 32'd1);

    // beq immediate, then illegal opcode
    drive(1, BEQ, 1, 0, 0, 0, 0);
    drive(1, ILL, 1, 0, 0, 0, 0);
    check("beq_imm", out_imm, 32'hFFFFFFFC);
    check("beq_rd_we", 32'(out_rd_we), 32'd0);
    drive(0, 0, 1, 0, 0, 0, 0);
    check("ill_flag", 32'({out_illegal, out_rd_we}), 32'({1'b1, 1'b0}));

    // asynchronous reset mid-stream
    drive(1, ADDI1, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 0);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    rstf = 1'b0;
    #1;
    check("rst_async_valid", 32'(out_valid), 32'd0);
    check("rst_async_ctl", 32'({out_rd, out_rd_we}), 32'd0);
    clear_model();
    drive(0, 0, 1, 0, 0, 0, 0);
    rstf = 1'b1;
    drive(1, ADD2, 1, 0, 0, 0, 0);
    check("rst_sb_clear", 32'(in_ready), 32'd1);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic       wbv;
      logic [4:0] wbr;
      wbv = 1'b0;
      wbr = 5'd0;
      if (retire_q.size() != 0 && $urandom_range(0, 2) != 0) begin
        wbv = 1'b1;
        wbr = retire_q.pop_front();
      end
      drive(1'($urandom_range(0, 9) < 7), rand_instr(), 1'($urandom_range(0, 3) != 0),
            wbv, wbr, $urandom, 1'($urandom_range(0, 19) == 0));
    end
    drive(0, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
